// File: rtl/stage_fetch0_pkg.sv
// Shared fetch0 definitions: default reset vector, fetch state enum and PC increment helper.
package stage_fetch0_pkg;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // Word-address increment; wraps naturally at 30 bits.
  function automatic logic [29:0] pc_incr(input logic [29:0] pc);
    return pc + 30'd1;
  endfunction

endpackage

// File: rtl/stage_fetch0_if.sv
// Fetch0 bundle: fetch1 handshake, icache read address and execute/CSR redirect inputs.
interface stage_fetch0_if;

  logic        fe1_stall;
  logic        fe1_exc;
  logic        fe0_valid;
  logic [29:0] fe0_read_addr;
  logic [19:0] fe0_ic_read_vpn;
  logic [9:0]  fe0_ic_read_index;
  logic        ex_br_taken;
  logic [29:0] ex_br_target;
  logic        csr_kill;
  logic [29:0] csr_newpc;

  modport master (
    input  fe1_stall, fe1_exc, ex_br_taken, ex_br_target, csr_kill, csr_newpc,
    output fe0_valid, fe0_read_addr, fe0_ic_read_vpn, fe0_ic_read_index
  );

  modport slave (
    output fe1_stall, fe1_exc, ex_br_taken, ex_br_target, csr_kill, csr_newpc,
    input  fe0_valid, fe0_read_addr, fe0_ic_read_vpn, fe0_ic_read_index
  );

endinterface

// File: rtl/stage_fetch0_perf_ctr.sv
// Single 32-bit wrapping event counter used by the fetch0 performance monitors.
module fetch0_perf_ctr (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_r;

  // Count one event per cycle, synchronous active-low clear.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      count_r <= 32'd0;
    end else if (inc) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/stage_fetch0.sv
// First fetch stage: owns the fetch PC, applies execute/CSR redirects, drives the icache read address.
// Optional performance counters are built only when FETCH0_PERF_EN is defined.
module stage_fetch0
  import stage_fetch0_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC
) (
  input  logic                 clk_core,
  input  logic                 reset_n,
  stage_fetch0_if.master       fe
`ifdef FETCH0_PERF_EN
  ,
  output logic [31:0]          fe0_perf_fetch,
  output logic [31:0]          fe0_perf_redirect,
  output logic [31:0]          fe0_perf_stall
`endif
);

  logic [29:0]  pc_r, pc_s;
  logic         valid_r;
  logic [29:0]  hold_pc_r, hold_pc_s;
  logic         pend_r, pend_s;
  logic [29:0]  pend_pc_r, pend_pc_s;
  fetch_state_e state_r, state_s;

  logic         redir_s;
  logic [29:0]  redir_pc_s;
  logic [29:0]  ic_addr_s;
  logic         fe0_valid_s;

  assign redir_s     = fe.csr_kill | fe.ex_br_taken;
  assign redir_pc_s  = fe.csr_kill ? fe.csr_newpc : fe.ex_br_target;
  assign fe0_valid_s = valid_r & ~pend_r & ~redir_s & (state_r == RUN);

  // A stalled fetch1 keeps re-reading the line it already accepted.
  assign ic_addr_s = fe.fe1_stall ? hold_pc_r : pc_r;

  assign fe.fe0_valid         = fe0_valid_s;
  assign fe.fe0_read_addr     = pc_r;
  assign fe.fe0_ic_read_vpn   = ic_addr_s[29:10];
  assign fe.fe0_ic_read_index = ic_addr_s[9:0];

  // Next-PC selection, pending-redirect capture and RUN/HALT transitions.
  always_comb begin
    pc_s      = pc_r;
    hold_pc_s = hold_pc_r;
    pend_s    = pend_r;
    pend_pc_s = pend_pc_r;
    state_s   = state_r;

    if (!fe.fe1_stall) begin
      hold_pc_s = pc_r;
      // A live redirect is newer than anything pending, so it also retires the pending one.
      if (redir_s) begin
        pc_s   = redir_pc_s;
        pend_s = 1'b0;
      end else if (pend_r) begin
        pc_s   = pend_pc_r;
        pend_s = 1'b0;
      end else if (valid_r && (state_r == RUN)) begin
        pc_s = pc_incr(pc_r);
      end else begin
        pc_s = pc_r;
      end
    end else begin
      if (redir_s) begin
        pend_s    = 1'b1;
        pend_pc_s = redir_pc_s;
      end else begin
        pend_s = pend_r;
      end
    end

    case (state_r)
      RUN: begin
        if (!redir_s && fe.fe1_exc && !fe.fe1_stall) begin
          state_s = HALT;
        end else begin
          state_s = RUN;
        end
      end
      HALT: begin
        if (redir_s) begin
          state_s = RUN;
        end else begin
          state_s = HALT;
        end
      end
      default: state_s = RUN;
    endcase
  end

  // Fetch state registers with synchronous active-low reset.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      pc_r      <= RESET_VEC[31:2];
      valid_r   <= 1'b1;
      hold_pc_r <= RESET_VEC[31:2];
      pend_r    <= 1'b0;
      pend_pc_r <= RESET_VEC[31:2];
      state_r   <= RUN;
    end else begin
      pc_r      <= pc_s;
      valid_r   <= 1'b1;
      hold_pc_r <= hold_pc_s;
      pend_r    <= pend_s;
      pend_pc_r <= pend_pc_s;
      state_r   <= state_s;
    end
  end

`ifdef FETCH0_PERF_EN
  fetch0_perf_ctr u_perf_fetch (
    .clk_core (clk_core),
    .reset_n  (reset_n),
    .inc      (fe0_valid_s & ~fe.fe1_stall),
    .count    (fe0_perf_fetch)
  );

  fetch0_perf_ctr u_perf_redirect (
    .clk_core (clk_core),
    .reset_n  (reset_n),
    .inc      (redir_s),
    .count    (fe0_perf_redirect)
  );

  fetch0_perf_ctr u_perf_stall (
    .clk_core (clk_core),
    .reset_n  (reset_n),
    .inc      (fe.fe1_stall & fe0_valid_s),
    .count    (fe0_perf_stall)
  );
`endif

endmodule

// File: tb/tb_stage_fetch0.sv
// Directed self-checking bench for stage_fetch0 (RESET_VEC=0x80000000); perf checks under FETCH0_PERF_EN.
module tb_stage_fetch0;

  logic clk_core;
  logic reset_n;
  int   n_vec;
  int   n_err;

  stage_fetch0_if fe_if ();

`ifdef FETCH0_PERF_EN
  logic [31:0] perf_fetch, perf_redirect, perf_stall;
`endif

  stage_fetch0 #(.RESET_VEC(32'h8000_0000)) dut (
    .clk_core (clk_core),
    .reset_n  (reset_n),
    .fe       (fe_if.master)
`ifdef FETCH0_PERF_EN
    ,
    .fe0_perf_fetch    (perf_fetch),
    .fe0_perf_redirect (perf_redirect),
    .fe0_perf_stall    (perf_stall)
`endif
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic clear_inputs();
    fe_if.fe1_stall    = 1'b0;
    fe_if.fe1_exc      = 1'b0;
    fe_if.ex_br_taken  = 1'b0;
    fe_if.ex_br_target = 30'h0;
    fe_if.csr_kill     = 1'b0;
    fe_if.csr_newpc    = 30'h0;
  endtask

  task automatic test_reset();
    logic [29:0] exp_pc;
    reset_n = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk_core);
    #1;
    reset_n = 1'b1;
    #1;
    exp_pc = 30'h2000_0000;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({fe_if.fe0_valid, fe_if.fe0_read_addr} !== {1'b1, exp_pc}) begin
        n_err++;
        $display("FAIL reset_seq[%0d] got v=%b pc=%h want v=1 pc=%h", i,
                 fe_if.fe0_valid, fe_if.fe0_read_addr, exp_pc);
      end
      exp_pc = exp_pc + 30'd1;
      tick();
    end
    n_vec++;
    if ({fe_if.fe0_ic_read_vpn, fe_if.fe0_ic_read_index} !== {20'h8_0000, 10'h003}) begin
      n_err++;
      $display("FAIL reset_icaddr got vpn=%h idx=%h want vpn=80000 idx=003",
               fe_if.fe0_ic_read_vpn, fe_if.fe0_ic_read_index);
    end
`ifdef FETCH0_PERF_EN
    n_vec++;
    if ({perf_fetch, perf_redirect, perf_stall} !== {32'd3, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL reset_perf got f=%0d r=%0d s=%0d want f=3 r=0 s=0",
               perf_fetch, perf_redirect, perf_stall);
    end
`endif
  endtask

  task automatic test_stall();
    // pc is 0x20000003 on entry; advance to 0x20000005
    tick();
    tick();
    fe_if.fe1_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if ({fe_if.fe0_ic_read_vpn, fe_if.fe0_ic_read_index, fe_if.fe0_read_addr}
          !== {20'h8_0000, 10'h004, 30'h2000_0005}) begin
        n_err++;
        $display("FAIL stall_hold[%0d] got vpn=%h idx=%h pc=%h want vpn=80000 idx=004 pc=20000005",
                 i, fe_if.fe0_ic_read_vpn, fe_if.fe0_ic_read_index, fe_if.fe0_read_addr);
      end
      tick();
    end
    fe_if.fe1_stall = 1'b0;
    #1;
    n_vec++;
    if (fe_if.fe0_ic_read_index !== 10'h005) begin
      n_err++;
      $display("FAIL stall_release_idx got %h want 005", fe_if.fe0_ic_read_index);
    end
    tick();
    n_vec++;
    if ({fe_if.fe0_valid, fe_if.fe0_read_addr} !== {1'b1, 30'h2000_0006}) begin
      n_err++;
      $display("FAIL stall_advance got v=%b pc=%h want v=1 pc=20000006",
               fe_if.fe0_valid, fe_if.fe0_read_addr);
    end
  endtask

  task automatic test_branch();
    fe_if.ex_br_taken  = 1'b1;
    fe_if.ex_br_target = 30'h100;
    #1;
    n_vec++;
    if (fe_if.fe0_valid !== 1'b0) begin
      n_err++;
      $display("FAIL branch_cycle_valid got %b want 0", fe_if.fe0_valid);
    end
    tick();
    clear_inputs();
    #1;
    n_vec++;
    if ({fe_if.fe0_valid, fe_if.fe0_read_addr} !== {1'b1, 30'h100}) begin
      n_err++;
      $display("FAIL branch_target got v=%b pc=%h want v=1 pc=100",
               fe_if.fe0_valid, fe_if.fe0_read_addr);
    end
  endtask

  task automatic test_double_redirect();
    fe_if.fe1_stall    = 1'b1;
    fe_if.csr_kill     = 1'b1;
    fe_if.csr_newpc    = 30'h40;
    fe_if.ex_br_taken  = 1'b1;
    fe_if.ex_br_target = 30'h100;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({fe_if.fe0_valid, fe_if.fe0_read_addr} !== {1'b0, 30'h100}) begin
        n_err++;
        $display("FAIL dbl_redir_pend[%0d] got v=%b pc=%h want v=0 pc=100",
                 i, fe_if.fe0_valid, fe_if.fe0_read_addr);
      end
      tick();
      clear_inputs();
      fe_if.fe1_stall = (i < 2);
      #1;
    end
    n_vec++;
    if ({fe_if.fe0_valid, fe_if.fe0_read_addr} !== {1'b1, 30'h40}) begin
      n_err++;
      $display("FAIL dbl_redir_target got v=%b pc=%h want v=1 pc=40",
               fe_if.fe0_valid, fe_if.fe0_read_addr);
    end
  endtask

  task automatic test_pend_overwrite();
    // pc=0x40; two successive stalled redirects, the later one must win
    fe_if.fe1_stall    = 1'b1;
    fe_if.ex_br_taken  = 1'b1;
    fe_if.ex_br_target = 30'h10;
    tick();
    clear_inputs();
    fe_if.fe1_stall = 1'b1;
    fe_if.csr_kill  = 1'b1;
    fe_if.csr_newpc = 30'h20;
    tick();
    clear_inputs();
    tick();
    n_vec++;
    if ({fe_if.fe0_valid, fe_if.fe0_read_addr} !== {1'b1, 30'h20}) begin
      n_err++;
      $display("FAIL pend_overwrite got v=%b pc=%h want v=1 pc=20",
               fe_if.fe0_valid, fe_if.fe0_read_addr);
    end
  endtask

  task automatic test_halt();
    // pc=0x20: exception accepted, pc steps once more then freezes
    fe_if.fe1_exc = 1'b1;
    tick();
    clear_inputs();
    #1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({fe_if.fe0_valid, fe_if.fe0_read_addr} !== {1'b0, 30'h21}) begin
        n_err++;
        $display("FAIL halt_frozen[%0d] got v=%b pc=%h want v=0 pc=21",
                 i, fe_if.fe0_valid, fe_if.fe0_read_addr);
      end
      tick();
    end
    fe_if.csr_kill  = 1'b1;
    fe_if.csr_newpc = 30'h3;
    tick();
    clear_inputs();
    #1;
    n_vec++;
    if ({fe_if.fe0_valid, fe_if.fe0_read_addr} !== {1'b1, 30'h3}) begin
      n_err++;
      $display("FAIL halt_resume got v=%b pc=%h want v=1 pc=3",
               fe_if.fe0_valid, fe_if.fe0_read_addr);
    end
    fe_if.fe1_exc      = 1'b1;
    fe_if.ex_br_taken  = 1'b1;
    fe_if.ex_br_target = 30'h200;
    tick();
    clear_inputs();
    tick();
    n_vec++;
    if ({fe_if.fe0_valid, fe_if.fe0_read_addr} !== {1'b1, 30'h201}) begin
      n_err++;
      $display("FAIL exc_vs_redirect got v=%b pc=%h want v=1 pc=201",
               fe_if.fe0_valid, fe_if.fe0_read_addr);
    end
  endtask

  task automatic test_wrap();
`ifdef FETCH0_PERF_EN
    logic [31:0] base_fetch;
`endif
    fe_if.csr_kill  = 1'b1;
    fe_if.csr_newpc = 30'h3FFF_FFFF;
    tick();
    clear_inputs();
    #1;
`ifdef FETCH0_PERF_EN
    base_fetch = perf_fetch;
`endif
    n_vec++;
    if ({fe_if.fe0_valid, fe_if.fe0_read_addr} !== {1'b1, 30'h3FFF_FFFF}) begin
      n_err++;
      $display("FAIL wrap_start got v=%b pc=%h want v=1 pc=3fffffff",
               fe_if.fe0_valid, fe_if.fe0_read_addr);
    end
    tick();
    n_vec++;
    if ({fe_if.fe0_valid, fe_if.fe0_read_addr} !== {1'b1, 30'h0}) begin
      n_err++;
      $display("FAIL wrap_zero got v=%b pc=%h want v=1 pc=0",
               fe_if.fe0_valid, fe_if.fe0_read_addr);
    end
    tick();
`ifdef FETCH0_PERF_EN
    n_vec++;
    if (perf_fetch - base_fetch !== 32'd2) begin
      n_err++;
      $display("FAIL wrap_perf_fetch got delta=%0d want 2", perf_fetch - base_fetch);
    end
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_stall();
    test_branch();
    test_double_redirect();
    test_pend_overwrite();
    test_halt();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
